// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder_4bit_struct.sv
// rtl/ripple_carry_adder_4bit_struct.sv - 4-bit ripple-carry adder built from gate primitives
module ripple_carry_adder_4bit_struct (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] t;

    assign c[0] = cin;
    assign cout = c[4];

    for (genvar i = 0; i < 4; i++) begin : g_fa
        xor u_p   (p[i],   a[i], b[i]);
        xor u_s   (sum[i], p[i], c[i]);
        and u_g   (g[i],   a[i], b[i]);
        and u_t   (t[i],   p[i], c[i]);
        or  u_c   (c[i+1], g[i], t[i]);
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder processing one nibble per clock, LSB first
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [WIDTH+NIBBLE_W-1:0] acc_cat;
    logic [WIDTH-1:0]    acc_nxt;
    logic                accept;
    logic                last;

    ripple_carry_adder_4bit_struct u_nibble_add (
        .a    (a_reg[NIBBLE_W-1:0]),
        .b    (b_reg[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at the bottom.
    assign acc_cat = {nib_sum, acc};
    assign acc_nxt = acc_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
    assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last    = (cnt == CNT_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_reg <= a_reg >> NIBBLE_W;
            b_reg <= b_reg >> NIBBLE_W;
            acc   <= acc_nxt;
            carry <= nib_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= nib_cout;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4)
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic c);
        a = x; b = y; cin = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered just after the accepting edge; returns in the cycle done is high (or on timeout).
    task automatic wait_done(output int nbusy, output bit got, output bit held);
        logic [15:0] s0;
        s0 = sum; nbusy = 0; got = 1'b0; held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (sum !== s0) held = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        step(); step();
        total++; if ({busy, done, sum, cout} !== 19'd0) begin bad++; $display("FAIL reset16 got=%h want=0", {busy, done, sum, cout}); end
        total++; if ({busy4, done4, sum4, cout4} !== 7'd0) begin bad++; $display("FAIL reset4 got=%h want=0", {busy4, done4, sum4, cout4}); end
        rst = 1'b0;
        step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL idle_flags got=%b want=00", {busy, done}); end
    endtask

    task automatic test_basic();
        int nb; bit got; bit held;
        launch(16'h1234, 16'h4321, 1'b0);
        wait_done(nb, got, held);
        total++; if (nb !== 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=4", nb); end
        total++; if (!got || {cout, sum} !== 17'h05555) begin bad++; $display("FAIL basic_sum got=%b/%h want=1/05555", got, {cout, sum}); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
    endtask

    task automatic test_carry_chain();
        int nb; bit got; bit held;
        launch(16'hFFFF, 16'h0001, 1'b0);
        wait_done(nb, got, held);
        total++; if (!got || {cout, sum} !== 17'h10000) begin bad++; $display("FAIL carry_chain got=%b/%h want=1/10000", got, {cout, sum}); end
        step();
    endtask

    task automatic test_back_to_back();
        int nb; bit got; bit held;
        launch(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(nb, got, held);
        total++; if (!got || {cout, sum} !== 17'h1FFFF) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/1ffff", got, {cout, sum}); end
        launch(16'h0001, 16'h0002, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b want=1", busy); end
        wait_done(nb, got, held);
        total++; if (nb !== 4 || !held) begin bad++; $display("FAIL b2b_busy_held got=%0d/%b want=4/1", nb, held); end
        total++; if (!got || {cout, sum} !== 17'h00003) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/00003", got, {cout, sum}); end
        step();
    endtask

    task automatic test_start_ignored();
        int dcnt = 0;
        logic [16:0] res = '0;
        launch(16'h00F0, 16'h0010, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (done) begin dcnt++; res = {cout, sum}; end
            if (busy) begin
                start = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        total++; if (dcnt !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dcnt); end
        total++; if (res !== 17'h00100) begin bad++; $display("FAIL ignore_sum got=%h want=00100", res); end
    endtask

    task automatic test_reset_mid_run();
        int nb; bit got; bit held;
        int dcnt = 0;
        launch(16'h0F0F, 16'h0101, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({busy, done, sum, cout} !== 19'd0) begin bad++; $display("FAIL midrun_reset got=%h want=0", {busy, done, sum, cout}); end
        for (int i = 0; i < 6; i++) begin
            if (done || busy) dcnt++;
            step();
        end
        total++; if (dcnt !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d want=0", dcnt); end
        launch(16'h8000, 16'h8000, 1'b0);
        wait_done(nb, got, held);
        total++; if (!got || {cout, sum} !== 17'h10000) begin bad++; $display("FAIL midrun_after got=%b/%h want=1/10000", got, {cout, sum}); end
        step();
    endtask

    task automatic test_random();
        int nb; bit got; bit held;
        logic [15:0] x; logic [15:0] y; logic c;
        logic [16:0] exp;
        for (int n = 0; n < 30; n++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            exp = model16(x, y, c);
            launch(x, y, c);
            wait_done(nb, got, held);
            total++;
            if (!got || nb !== 4 || !held || {cout, sum} !== exp) begin
                bad++;
                $display("FAIL random%0d %h+%h+%b got=%b/%0d/%b/%h want=1/4/1/%h", n, x, y, c, got, nb, held, {cout, sum}, exp);
            end
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k <= int'($urandom_range(0, 2)); k++) step();
            end
        end
    endtask

    task automatic test_width4();
        logic [3:0] x; logic [3:0] y; logic c;
        logic [4:0] exp;
        bit got;
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        total++; if ({busy4, done4} !== 2'b10) begin bad++; $display("FAIL w4_run got=%b want=10", {busy4, done4}); end
        step();
        total++; if ({busy4, done4, cout4, sum4} !== 7'b01_1_0001) begin bad++; $display("FAIL w4_basic got=%b want=0110001", {busy4, done4, cout4, sum4}); end
        step();
        for (int n = 0; n < 10; n++) begin
            x = 4'($urandom); y = 4'($urandom); c = 1'($urandom);
            exp = 5'(x) + 5'(y) + 5'(c);
            a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
            step();
            start4 = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (done4) begin got = 1'b1; break; end
                step();
            end
            total++;
            if (!got || {cout4, sum4} !== exp) begin
                bad++;
                $display("FAIL w4_random%0d %h+%h+%b got=%b/%h want=1/%h", n, x, y, c, got, {cout4, sum4}, exp);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder. Adds two WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first.
- Uses a single 4-bit ripple-carry stage. The inter-nibble carry is held in a flop.
- Sits between the operand source and the result consumer. Trades latency for area when a WIDTH-bit combinational adder is too large or too slow.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam (not overridable). Number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when accepting (IDLE or DONE)
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: sum/cout newly valid
- sum  output  WIDTH  registered result; held until the next completion
- cout  output  1  registered carry-out of the MSB nibble

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high and overrides all else.
  - On reset: state=IDLE, busy=0, done=0, sum=0, cout=0, internal operand/shift regs=0, carry flop=0, nibble counter=0.
- States: IDLE, RUN, DONE. Encoding is free; outputs are decoded from registered state (no combinational path from inputs to outputs).
- IDLE:
  - start=1 at an edge: latch a, b, cin into internal regs (carry flop<=cin), counter<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - Feed a_reg[3:0], b_reg[3:0] and the carry flop to the 4-bit adder.
  - The 4-bit sum shifts into the top of the result shift reg (right shift by 4).
  - a_reg and b_reg shift right by 4. Carry flop <= adder carry-out. Counter increments.
  - On the edge where counter==NIBBLES-1: sum <= completed shift value, cout <= final carry, go to DONE.
- DONE (done=1, busy=0, lasts exactly one cycle):
  - start=1: accept new operands exactly as in IDLE and go to RUN (back-to-back; done still pulses for this cycle).
  - start=0: go to IDLE.
- Latency: accepting edge E0; nibble i is processed at edge E(i+1); done is high in the cycle after E(NIBBLES). Throughput is one result per NIBBLES+1 cycles.
- start while in RUN is ignored; operands and cin are not re-sampled.
- sum/cout change only on the completing edge or on reset. The previous result stays visible during RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and the next accepted start computes correctly.
- WIDTH=4: NIBBLES=1. RUN lasts one cycle, then DONE.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE) and the NIBBLE_W=4 constant.
- Counter width: $clog2(NIBBLES), minimum 1.
- One sub-module: the existing ripple_carry_adder_4bit_struct, instantiated once as the per-nibble adder. No re-implementation inline.
- Control, shift registers and output registers live in this module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start pulsed at E0 -> busy high for 4 cycles; done at cycle after E4; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all four nibbles via the carry flop).
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then hold start=1 during the DONE cycle with a=0x0001, b=0x0002 -> immediate second op; sum=0x0003, cout=0 after 4 more RUN cycles.
- During RUN of a=0x00F0+b=0x0010, assert start with different operands on every RUN cycle -> ignored; result sum=0x0100, cout=0; done pulses once.
- Assert rst on the 2nd RUN cycle -> next edge: busy=0, done=0, sum=0, cout=0, state IDLE, no done pulse. Then run 0x8000+0x8000 -> sum=0x0000, cout=1.
- WIDTH=4 instance: a=0x9, b=0x8, cin=0 -> one RUN cycle; done at cycle after E1; sum=0x1, cout=1.
